// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo sequencer: note codes, the stored
// alarm melody, FSM state encoding and the code-to-one-hot mapping.
package piezo_pkg;

   // Note codes: 0..7 map to C..HC, code 8 is a rest (silence).
   localparam logic [3:0] CODE_C    = 4'd0;
   localparam logic [3:0] CODE_D    = 4'd1;
   localparam logic [3:0] CODE_E    = 4'd2;
   localparam logic [3:0] CODE_F    = 4'd3;
   localparam logic [3:0] CODE_G    = 4'd4;
   localparam logic [3:0] CODE_A    = 4'd5;
   localparam logic [3:0] CODE_B    = 4'd6;
   localparam logic [3:0] CODE_HC   = 4'd7;
   localparam logic [3:0] CODE_REST = 4'd8;

   localparam int MELODY_LEN = 8;

   // One melody step: note code plus its length in duration ticks (never 0).
   typedef struct packed {
      logic [3:0] code;
      logic [3:0] dur;
   } mel_entry_t;

   localparam mel_entry_t MELODY [MELODY_LEN] = '{
      '{CODE_C,    4'd4},
      '{CODE_E,    4'd4},
      '{CODE_G,    4'd4},
      '{CODE_HC,   4'd8},
      '{CODE_G,    4'd4},
      '{CODE_E,    4'd4},
      '{CODE_C,    4'd8},
      '{CODE_REST, 4'd8}
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MANUAL,
      ST_BEEP,
      ST_MEL_NOTE,
      ST_MEL_GAP
   } state_t;

   // Code 0 (C) drives bit 7, code 7 (HC) drives bit 0; anything else is silent.
   function automatic logic [7:0] note_onehot(input logic [3:0] code);
      if (code <= CODE_HC) return 8'h80 >> code[2:0];
      else                 return 8'h00;
   endfunction

endpackage

// File: rtl/piezo_tick_timer.sv
// Duration-tick prescaler: divides CLK by TICK_DIV and emits a one-cycle
// tick on the last cycle of each period. A synchronous restart pins the
// count at zero so a new segment always starts on a full tick period.
module piezo_tick_timer #(
   parameter int TICK_DIV = 1000
) (
   input  logic CLK,
   input  logic RESETN,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(TICK_DIV - 1));

   // Prescaler count: wraps on tick, forced to zero by restart.
   always_ff @(posedge CLK or negedge RESETN) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block ordering.
      if (!RESETN) begin
         count <= '0;
      end else if (restart || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/piezo_sequencer.sv
// Arbitrates the piezo note-select between the alarm melody, the
// confirmation beep and the manual keypad (fixed priority in that order),
// times notes/gaps/beeps in duration ticks and drives a registered
// one-hot NOTE plus BUSY and a MEL_DONE pulse.
module piezo_sequencer
   import piezo_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int GAP_TICKS  = 1,
   parameter int BEEP_TICKS = 2
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic [7:0] KEY,
   input  logic       ALARM_REQ,
   input  logic       BEEP_REQ,
   output logic [7:0] NOTE,
   output logic       BUSY,
   output logic       MEL_DONE
);

   localparam int GAP_W  = (GAP_TICKS  > 1) ? $clog2(GAP_TICKS)  : 1;
   localparam int BEEP_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

   localparam logic [7:0] BEEP_NOTE = 8'b0000_0001;

   state_t            state;
   logic [2:0]        idx;
   logic [3:0]        dur_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [BEEP_W-1:0] beep_cnt;

   logic       tick;
   logic       restart;
   logic       key_valid;
   logic       note_last;
   logic       gap_last;
   logic       beep_last;
   mel_entry_t cur;
   mel_entry_t nxt;

   // A key press counts only when exactly one bit is set.
   assign key_valid = (KEY != 8'h00) && ((KEY & (KEY - 8'h01)) == 8'h00);

   assign cur = MELODY[idx];
   assign nxt = MELODY[idx + 3'd1];

   assign note_last = tick && (dur_cnt  == cur.dur - 4'd1);
   assign gap_last  = tick && (gap_cnt  == GAP_W'(GAP_TICKS - 1));
   assign beep_last = tick && (beep_cnt == BEEP_W'(BEEP_TICKS - 1));

   // Segment ends always coincide with a tick, where the prescaler wraps to
   // zero on its own. The only other segment starts come out of IDLE/MANUAL
   // or an alarm preempting a beep mid-tick, so hold the prescaler there.
   assign restart = (state == ST_IDLE) || (state == ST_MANUAL) ||
                    ((state == ST_BEEP) && ALARM_REQ);

   piezo_tick_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_timer (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .restart (restart),
      .tick    (tick)
   );

   // Sequencer FSM with registered NOTE/BUSY/MEL_DONE and segment counters.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state    <= ST_IDLE;
         idx      <= 3'd0;
         dur_cnt  <= 4'd0;
         gap_cnt  <= '0;
         beep_cnt <= '0;
         NOTE     <= 8'h00;
         BUSY     <= 1'b0;
         MEL_DONE <= 1'b0;
      end else begin
         MEL_DONE <= 1'b0;
         unique case (state)
            ST_IDLE, ST_MANUAL: begin
               if (ALARM_REQ) begin
                  state   <= ST_MEL_NOTE;
                  idx     <= 3'd0;
                  dur_cnt <= 4'd0;
                  NOTE    <= note_onehot(MELODY[0].code);
                  BUSY    <= 1'b1;
               end else if (BEEP_REQ) begin
                  state    <= ST_BEEP;
                  beep_cnt <= '0;
                  NOTE     <= BEEP_NOTE;
                  BUSY     <= 1'b1;
               end else if (key_valid) begin
                  state <= ST_MANUAL;
                  NOTE  <= KEY;
               end else begin
                  state <= ST_IDLE;
                  NOTE  <= 8'h00;
               end
            end

            ST_BEEP: begin
               if (ALARM_REQ) begin
                  state   <= ST_MEL_NOTE;
                  idx     <= 3'd0;
                  dur_cnt <= 4'd0;
                  NOTE    <= note_onehot(MELODY[0].code);
               end else if (beep_last) begin
                  state <= ST_IDLE;
                  NOTE  <= 8'h00;
                  BUSY  <= 1'b0;
               end else if (tick) begin
                  beep_cnt <= beep_cnt + 1'b1;
               end
            end

            ST_MEL_NOTE: begin
               if (note_last) begin
                  state   <= ST_MEL_GAP;
                  gap_cnt <= '0;
                  NOTE    <= 8'h00;
               end else if (tick) begin
                  dur_cnt <= dur_cnt + 4'd1;
               end
            end

            ST_MEL_GAP: begin
               if (gap_last) begin
                  if (ALARM_REQ) begin
                     state   <= ST_MEL_NOTE;
                     idx     <= idx + 3'd1;
                     dur_cnt <= 4'd0;
                     NOTE    <= note_onehot(nxt.code);
                  end else begin
                     state    <= ST_IDLE;
                     NOTE     <= 8'h00;
                     BUSY     <= 1'b0;
                     MEL_DONE <= 1'b1;
                  end
               end else if (tick) begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
               NOTE  <= 8'h00;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piezo_sequencer.sv
// Self-checking bench for piezo_sequencer (TICK_DIV=4, GAP_TICKS=1,
// BEEP_TICKS=2). Expected melody output is derived from the note table
// as a per-cycle list of segments; keypad/beep expectations come straight
// from the arbitration rules.
module tb_piezo_sequencer;

   localparam int TD = 4;
   localparam int GT = 1;
   localparam int BT = 2;

   logic       CLK = 1'b0;
   logic       RESETN;
   logic [7:0] KEY;
   logic       ALARM_REQ;
   logic       BEEP_REQ;
   logic [7:0] NOTE;
   logic       BUSY;
   logic       MEL_DONE;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference melody: note codes (0=C .. 7=HC, 8=rest) and tick lengths.
   int mel_code [8] = '{0, 2, 4, 7, 4, 2, 0, 8};
   int mel_dur  [8] = '{4, 4, 4, 8, 4, 4, 8, 8};

   piezo_sequencer #(
      .TICK_DIV   (TD),
      .GAP_TICKS  (GT),
      .BEEP_TICKS (BT)
   ) dut (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .KEY       (KEY),
      .ALARM_REQ (ALARM_REQ),
      .BEEP_REQ  (BEEP_REQ),
      .NOTE      (NOTE),
      .BUSY      (BUSY),
      .MEL_DONE  (MEL_DONE)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] tone(input int code);
      logic [7:0] one;
      one = 8'h80;
      if (code < 8) return one >> code;
      return 8'h00;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_out(input string name, input logic [7:0] en, input logic eb,
                            input logic ed);
      n_tests++;
      if (NOTE !== en || BUSY !== eb || MEL_DONE !== ed) begin
         n_fail++;
         if (n_fail < 40)
            $display("FAIL %s @%0t: got NOTE=%h BUSY=%b DONE=%b, expected NOTE=%h BUSY=%b DONE=%b",
                     name, $time, NOTE, BUSY, MEL_DONE, en, eb, ed);
      end
   endtask

   task automatic test_reset();
      RESETN = 1'b0; KEY = 8'h00; ALARM_REQ = 1'b0; BEEP_REQ = 1'b0;
      repeat (3) step();
      check_out("reset_held", 8'h00, 1'b0, 1'b0);
      RESETN = 1'b1;
      step();
      check_out("reset_release", 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_manual();
      KEY = 8'h20; step();
      check_out("manual_20", 8'h20, 1'b0, 1'b0);
      KEY = 8'h21; step();
      check_out("manual_21_invalid", 8'h00, 1'b0, 1'b0);
      KEY = 8'h08; step();
      check_out("manual_08", 8'h08, 1'b0, 1'b0);
      // Random keys, valid one-hot and arbitrary bytes mixed.
      for (int i = 0; i < 24; i++) begin
         logic [7:0] k;
         if ($urandom_range(1) == 1) k = 8'h01 << $urandom_range(7);
         else                        k = 8'($urandom);
         KEY = k; step();
         check_out("manual_rand", ($countones(k) == 1) ? k : 8'h00, 1'b0, 1'b0);
      end
      KEY = 8'h00; step();
      check_out("manual_release", 8'h00, 1'b0, 1'b0);
   endtask

   task automatic play_beep(input string name);
      BEEP_REQ = 1'b1; step(); BEEP_REQ = 1'b0;
      for (int i = 0; i < BT * TD; i++) begin
         check_out(name, 8'h01, 1'b1, 1'b0);
         step();
      end
   endtask

   task automatic test_beep();
      bit seen;
      play_beep("beep_idle");
      check_out("beep_idle_end", 8'h00, 1'b0, 1'b0);
      step();
      check_out("beep_idle_after", 8'h00, 1'b0, 1'b0);

      KEY = 8'h80; step();
      check_out("beep_key_manual", 8'h80, 1'b0, 1'b0);
      play_beep("beep_over_key");
      // Manual note must come back within a bounded number of cycles.
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         if (NOTE === 8'h80 && BUSY === 1'b0) seen = 1'b1;
         else if (NOTE !== 8'h00 || BUSY !== 1'b0) break;
         else step();
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL beep_resume_manual: got NOTE=%h BUSY=%b, expected NOTE=80 BUSY=0", NOTE, BUSY);
      end
      KEY = 8'h00; step(); step();
      check_out("beep_key_release", 8'h00, 1'b0, 1'b0);
   endtask

   // Starts the alarm, drops it after output sample s_drop and compares
   // every cycle against the per-segment expectation from the note table.
   task automatic run_melody(input string name, input int s_drop, input bit collide,
                             input bit random_beeps);
      logic [7:0] en[$];
      logic       eb[$];
      logic       ed[$];
      int a, b, j, b_stop;
      a = 0; j = 0;
      forever begin
         int n = j % 8;
         for (int c = 0; c < mel_dur[n] * TD; c++) begin
            en.push_back(tone(mel_code[n])); eb.push_back(1'b1); ed.push_back(1'b0);
         end
         for (int c = 0; c < GT * TD; c++) begin
            en.push_back(8'h00); eb.push_back(1'b1); ed.push_back(1'b0);
         end
         b = a + (mel_dur[n] + GT) * TD;
         if (b > s_drop) break;
         a = b; j++;
      end
      b_stop = b;
      en.push_back(8'h00); eb.push_back(1'b0); ed.push_back(1'b1);
      for (int c = 0; c < 6; c++) begin
         en.push_back(8'h00); eb.push_back(1'b0); ed.push_back(1'b0);
      end

      ALARM_REQ = 1'b1; BEEP_REQ = collide;
      step();
      BEEP_REQ = 1'b0;
      for (int s = 0; s < en.size(); s++) begin
         check_out(name, en[s], eb[s], ed[s]);
         if (s == s_drop) ALARM_REQ = 1'b0;
         BEEP_REQ = (random_beeps && s < b_stop) ? ($urandom_range(5) == 0) : 1'b0;
         step();
      end
      BEEP_REQ = 1'b0;
   endtask

   task automatic test_melody();
      // Full loop plus wrap back to the first note, alarm+beep collision at start.
      run_melody("melody_loop", 215, 1'b1, 1'b1);
   endtask

   task automatic test_alarm_stop();
      // Drop the alarm somewhere inside the HC note (index 3).
      run_melody("alarm_stop_hc", $urandom_range(91, 60), 1'b0, 1'b1);
      run_melody("alarm_stop_hc_first", 60, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      ALARM_REQ = 1'b1; step();
      repeat (10) step();
      check_out("reset_mid_playing", 8'h80, 1'b1, 1'b0);
      #2 RESETN = 1'b0;
      #1;
      check_out("reset_mid_async", 8'h00, 1'b0, 1'b0);
      ALARM_REQ = 1'b0;
      step();
      RESETN = 1'b1;
      step();
      check_out("reset_mid_release", 8'h00, 1'b0, 1'b0);
      step();
      check_out("reset_mid_idle", 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_manual();
      test_beep();
      test_melody();
      test_alarm_stop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
